// File: rtl/scratchpad_pkg.sv
// Shared types and constants for the burst-read scratchpad.
package scratchpad_pkg;

    localparam int SP_DATA_WIDTH = 16;
    localparam int SP_ADDR_WIDTH = 8;
    localparam int SP_READ_BW    = 4;
    localparam int SP_BEAT_WIDTH = 8;
    localparam int MAX_READ_LAT  = 4;

    typedef logic [SP_READ_BW-1:0][SP_DATA_WIDTH-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } burst_state_t;

    typedef struct packed {
        logic [SP_ADDR_WIDTH-1:0] addr;
        logic [SP_ADDR_WIDTH-1:0] stride;
        logic [SP_BEAT_WIDTH-1:0] beats;
    } burst_req_t;

endpackage

// File: rtl/sp_read_pipe.sv
// Fixed-latency delay line carrying a valid bit and a beat payload.
module sp_read_pipe #(
    parameter int LAT   = 1,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [WIDTH-1:0] issue_data,
    output logic             beat_valid,
    output logic [WIDTH-1:0] beat_data
);

    logic [LAT-1:0]   vld;
    logic [WIDTH-1:0] pay [LAT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) pay[i] <= '0;
        end else begin
            vld[0] <= issue_valid;
            pay[0] <= issue_data;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                pay[i] <= pay[i-1];
            end
        end
    end

    assign beat_valid = vld[LAT-1];
    assign beat_data  = pay[LAT-1];

endmodule

// File: rtl/burst_read_scratchpad.sv
// Scratchpad with host write port and strided multi-lane burst reads.
// SCRATCHPAD_WRAP_EN: lane addresses wrap modulo DEPTH instead of zero-fill + rd_oob.
//
// state | meaning
// IDLE  | ready for a request; beat 0 issued in the acceptance cycle
// ISSUE | one read per cycle until the beat counter runs out
// DRAIN | waiting for the last beat to leave the read pipe
module burst_read_scratchpad
    import scratchpad_pkg::*;
#(
    parameter int DATA_WIDTH = SP_DATA_WIDTH,
    parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
    parameter int READ_BW    = SP_READ_BW,
    parameter int DEPTH      = 256,
    parameter int READ_LAT   = 1,
    parameter int BEAT_WIDTH = SP_BEAT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [ADDR_WIDTH-1:0]         req_stride,
    input  logic [BEAT_WIDTH-1:0]         req_beats,
    output logic                          rd_valid,
    output logic [READ_BW*DATA_WIDTH-1:0] rd_data,
    output logic                          rd_oob,
    output logic                          rd_last,
    output logic                          done
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PAY_W  = READ_BW*DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = DEPTH[ADDR_WIDTH:0];
    localparam logic [BEAT_WIDTH-1:0] ONE_BEAT = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    burst_state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]         cur_addr, cur_addr_nxt, stride, stride_nxt;
    logic [BEAT_WIDTH-1:0]         beats_left, beats_left_nxt;
    logic                          done_nxt;
    logic                          iss_valid, iss_last, iss_oob;
    logic [ADDR_WIDTH-1:0]         iss_addr;
    logic [READ_BW*DATA_WIDTH-1:0] iss_data;
    logic [PAY_W-1:0]              pipe_pay;

    // Memory is intentionally left out of reset; contents survive a burst abort.
    always_ff @(posedge clock) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W))
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    end

    always_comb begin
        logic [ADDR_WIDTH:0] lane_idx;
        lane_idx = '0;
        iss_data = '0;
        iss_oob  = 1'b0;
        for (int i = 0; i < READ_BW; i++) begin
            lane_idx = {1'b0, iss_addr} + (ADDR_WIDTH+1)'(i);
`ifdef SCRATCHPAD_WRAP_EN
            lane_idx = lane_idx % DEPTH_W;
            iss_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[lane_idx[MEM_AW-1:0]];
`else
            if (lane_idx >= DEPTH_W)
                iss_oob = 1'b1;
            else
                iss_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[lane_idx[MEM_AW-1:0]];
`endif
        end
        if (!iss_valid) begin
            iss_data = '0;
            iss_oob  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            stride     <= '0;
            beats_left <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= cur_addr_nxt;
            stride     <= stride_nxt;
            beats_left <= beats_left_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cur_addr_nxt   = cur_addr;
        stride_nxt     = stride;
        beats_left_nxt = beats_left;
        req_ready      = 1'b0;
        iss_valid      = 1'b0;
        iss_addr       = cur_addr;
        iss_last       = 1'b0;
        done_nxt       = rd_valid && rd_last;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stride_nxt     = req_stride;
                    cur_addr_nxt   = req_addr + req_stride;
                    beats_left_nxt = req_beats - ONE_BEAT;
                    if (req_beats == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        iss_valid = 1'b1;
                        iss_addr  = req_addr;
                        iss_last  = (req_beats == ONE_BEAT);
                        state_nxt = iss_last ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                iss_valid      = 1'b1;
                iss_last       = (beats_left == ONE_BEAT);
                cur_addr_nxt   = cur_addr + stride;
                beats_left_nxt = beats_left - ONE_BEAT;
                if (iss_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (rd_valid && rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sp_read_pipe #(
        .LAT   (READ_LAT),
        .WIDTH (PAY_W)
    ) u_read_pipe (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (iss_valid),
        .issue_data  ({iss_last, iss_oob, iss_data}),
        .beat_valid  (rd_valid),
        .beat_data   (pipe_pay)
    );

    assign rd_last = pipe_pay[PAY_W-1];
    assign rd_oob  = pipe_pay[PAY_W-2];
    assign rd_data = pipe_pay[PAY_W-3:0];

endmodule

// File: tb/tb_burst_read_scratchpad.sv
// Directed bench: READ_LAT=1 and READ_LAT=3 instances driven in parallel, DEPTH=140, mem[i]=i.
module tb_burst_read_scratchpad;
    import scratchpad_pkg::*;

    localparam int DW    = SP_DATA_WIDTH;
    localparam int AW    = SP_ADDR_WIDTH;
    localparam int BW    = SP_READ_BW;
    localparam int BTW   = SP_BEAT_WIDTH;
    localparam int DEPTH = 140;

    logic           clock = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           req_valid;
    logic [AW-1:0]  req_addr, req_stride;
    logic [BTW-1:0] req_beats;

    logic           rdy1, vld1, oob1, last1, done1;
    logic           rdy3, vld3, oob3, last3, done3;
    logic [BW*DW-1:0] data1, data3;

    always #5 clock = ~clock;

    burst_read_scratchpad #(.DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_addr), .req_stride(req_stride),
        .req_beats(req_beats), .rd_valid(vld1), .rd_data(data1), .rd_oob(oob1),
        .rd_last(last1), .done(done1)
    );

    burst_read_scratchpad #(.DEPTH(DEPTH), .READ_LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(rdy3), .req_addr(req_addr), .req_stride(req_stride),
        .req_beats(req_beats), .rd_valid(vld3), .rd_data(data3), .rd_oob(oob3),
        .rd_last(last3), .done(done3)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Per-instance beat log, index 0 = READ_LAT 1, index 1 = READ_LAT 3.
    logic [BW*DW-1:0] beat_data [2][16];
    int nbeat[2], first_cyc[2], last_cyc[2], last_idx[2];
    int ndone[2], done_cyc[2], stale[2], oob_cnt[2];

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            nbeat[d] = 0; first_cyc[d] = -1; last_cyc[d] = -1; last_idx[d] = -1;
            ndone[d] = 0; done_cyc[d] = -1; stale[d] = 0; oob_cnt[d] = 0;
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [BW*DW-1:0] dat,
                       input logic o, input logic l, input logic dn);
        if (v) begin
            if (nbeat[d] < 16) beat_data[d][nbeat[d]] = dat;
            if (nbeat[d] == 0) first_cyc[d] = cyc;
            last_cyc[d] = cyc;
            if (l) last_idx[d] = nbeat[d];
            if (o) oob_cnt[d]++;
            nbeat[d]++;
        end else if (dat != '0 || o || l) begin
            stale[d]++;
        end
        if (dn) begin
            ndone[d]++;
            done_cyc[d] = cyc;
        end
    endtask

    always @(negedge clock) begin
        mon(0, vld1, data1, oob1, last1, done1);
        mon(1, vld3, data3, oob3, last3, done3);
    end

    function automatic logic [63:0] lanes4(input int b);
        return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
    endfunction

    task automatic host_write(input int a, input int v);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(v);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Presents a one-cycle request at a negedge; acc is the acceptance cycle number.
    task automatic issue(input int a, input int s, input int n, output int acc);
        @(negedge clock);
        clear_mon();
        req_addr = AW'(a); req_stride = AW'(s); req_beats = BTW'(n); req_valid = 1'b1;
        acc = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic check_burst(input int d, input int lat, input int acc,
                               input int nb, input int base, input int stride);
        check($sformatf("beats_%0d", d), 64'(nbeat[d]), 64'(nb));
        check($sformatf("first_lat_%0d", d), 64'(first_cyc[d] - acc), 64'(lat));
        check($sformatf("contig_%0d", d), 64'(last_cyc[d] - first_cyc[d]), 64'(nb - 1));
        check($sformatf("last_idx_%0d", d), 64'(last_idx[d]), 64'(nb - 1));
        check($sformatf("done_cnt_%0d", d), 64'(ndone[d]), 64'd1);
        check($sformatf("done_cyc_%0d", d), 64'(done_cyc[d]), 64'(last_cyc[d] + 1));
        check($sformatf("stale_%0d", d), 64'(stale[d]), 64'd0);
        check($sformatf("oob_%0d", d), 64'(oob_cnt[d]), 64'd0);
        for (int k = 0; k < nb && k < 16; k++)
            check($sformatf("data_%0d_b%0d", d, k), beat_data[d][k], lanes4(base + k*stride));
    endtask

    initial begin
        int acc;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; req_stride = '0; req_beats = '0;
        clear_mon();
        repeat (3) @(negedge clock);
        check("rst_ready", {62'd0, rdy1, rdy3}, 64'd3);
        check("rst_valid", {62'd0, vld1, vld3}, 64'd0);
        check("rst_data1", data1, 64'd0);
        check("rst_data3", data3, 64'd0);
        check("rst_flags", {60'd0, oob1, oob3, last1, last3}, 64'd0);
        check("rst_done", {62'd0, done1, done3}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) host_write(i, i);

        // Basic strided burst on both latencies.
        issue(0, 8, 8, acc);
        repeat (16) @(negedge clock);
        check_burst(0, 1, acc, 8, 0, 8);
        check_burst(1, 3, acc, 8, 0, 8);

        // Lanes straddling the end of memory.
        issue(138, 0, 1, acc);
        repeat (6) @(negedge clock);
`ifdef SCRATCHPAD_WRAP_EN
        check("edge_data1", beat_data[0][0], 64'h0001_0000_008B_008A);
        check("edge_data3", beat_data[1][0], 64'h0001_0000_008B_008A);
        check("edge_oob", 64'(oob_cnt[0] + oob_cnt[1]), 64'd0);
`else
        check("edge_data1", beat_data[0][0], 64'h0000_0000_008B_008A);
        check("edge_data3", beat_data[1][0], 64'h0000_0000_008B_008A);
        check("edge_oob", 64'(oob_cnt[0] + oob_cnt[1]), 64'd2);
`endif
        check("edge_beats", 64'(nbeat[0] + nbeat[1]), 64'd2);

        // Zero-beat request: done next cycle, no data, ready held.
        issue(5, 1, 0, acc);
        check("zero_done", {62'd0, done1, done3}, 64'd3);
        check("zero_ready", {62'd0, rdy1, rdy3}, 64'd3);
        @(negedge clock);
        check("zero_done_pulse", {62'd0, done1, done3}, 64'd0);
        repeat (4) @(negedge clock);
        check("zero_beats", 64'(nbeat[0] + nbeat[1]), 64'd0);

        // Request in the done cycle: lat1 is idle and takes it, lat3 is draining and drops it.
        issue(0, 4, 2, acc);
        repeat (2) @(negedge clock);
        check("b2b_done1", {63'd0, done1}, 64'd1);
        check("b2b_ready", {62'd0, rdy1, rdy3}, 64'd2);
        req_addr = AW'(20); req_stride = AW'(1); req_beats = BTW'(1); req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("b2b_beats1", 64'(nbeat[0]), 64'd3);
        check("b2b_data1", beat_data[0][2], lanes4(20));
        check("b2b_done_cnt1", 64'(ndone[0]), 64'd2);
        check("b2b_beats3", 64'(nbeat[1]), 64'd2);
        check("b2b_data3", beat_data[1][1], lanes4(4));
        check("b2b_done_cnt3", 64'(ndone[1]), 64'd1);

        // Write and read of word 70 in the same cycle.
        @(negedge clock);
        clear_mon();
        req_addr = AW'(68); req_stride = '0; req_beats = BTW'(1); req_valid = 1'b1;
        wr_en = 1'b1; wr_addr = AW'(70); wr_data = DW'(16'h00AA);
        @(negedge clock);
        req_valid = 1'b0; wr_en = 1'b0;
        repeat (6) @(negedge clock);
        check("rbw_old1", beat_data[0][0], 64'h0047_0046_0045_0044);
        check("rbw_old3", beat_data[1][0], 64'h0047_0046_0045_0044);
        issue(68, 0, 1, acc);
        repeat (6) @(negedge clock);
        check("rbw_new1", beat_data[0][0], 64'h0047_00AA_0045_0044);
        check("rbw_new3", beat_data[1][0], 64'h0047_00AA_0045_0044);
        host_write(70, 70);

        // Reset while lat1 is delivering beat 3 of 8.
        issue(0, 8, 8, acc);
        repeat (2) @(negedge clock);
        check("abort_pre_valid", {63'd0, vld1}, 64'd1);
        reset = 1'b1;
        #1;
        clear_mon();
        check("abort_valid", {62'd0, vld1, vld3}, 64'd0);
        check("abort_data", data1 | data3, 64'd0);
        check("abort_ready", {62'd0, rdy1, rdy3}, 64'd3);
        check("abort_done", {62'd0, done1, done3}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("abort_quiet", 64'(nbeat[0] + nbeat[1] + ndone[0] + ndone[1]), 64'd0);
        issue(8, 8, 2, acc);
        repeat (8) @(negedge clock);
        check_burst(0, 1, acc, 2, 8, 8);
        check_burst(1, 3, acc, 2, 8, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
